rx_output_buffer: RTL and testbench

Receive-side counterpart of the transmit input buffer. It captures each frame the UART receiver completes (data byte plus parity/stop error flags) into a small FIFO and presents it to the downstream consumer over a valid/ready handshake. This lets the consumer stall without losing frames while the receiver keeps running. Frames arriving while the FIFO is full and not being drained are dropped and recorded in a sticky overrun flag.

---
 rtl/rx_output_buffer_pkg.sv | 15 +
 rtl/rx_buf_mem.sv | 28 ++
 rtl/rx_output_buffer.sv | 71 +++++++
 tb/tb_rx_output_buffer.sv | 122 ++++++++++++
 4 files changed

// File: rtl/rx_output_buffer_pkg.sv
// rx_output_buffer_pkg: frame layout and defaults shared by the UART receive path.
//   Frame record = {ParErr, StpErr, Pdata}; width 2**DataWIDTH+2.
package rx_output_buffer_pkg;
    localparam int DATA_WIDTH_DEF = 3;
    localparam int DEPTH_LOG2_DEF = 2;
    function automatic int frame_w(input int dw);
        return 2**dw + 2;
    endfunction
    function automatic int stp_err_bit(input int dw);
        return 2**dw;
    endfunction
    function automatic int par_err_bit(input int dw);
        return 2**dw + 1;
    endfunction
endpackage

// File: rtl/rx_buf_mem.sv
// rx_buf_mem: frame storage, synchronous write, asynchronous read, synchronous clear.
//   clk/rst_n   clock, active-low synchronous reset (clears every entry)
//   we/wa/wd    write enable, address, frame record
//   ra/rd       read address, frame record at ra
module rx_buf_mem #(
    parameter int W  = 10,
    parameter int AW = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we,
    input  logic [AW-1:0] wa,
    input  logic [W-1:0]  wd,
    input  logic [AW-1:0] ra,
    output logic [W-1:0]  rd
);
    logic [W-1:0] mem [2**AW];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 2**AW; i++) mem[i] <= '0;
        end else if (we) begin
            mem[wa] <= wd;
        end
    end

    assign rd = mem[ra];
endmodule

// File: rtl/rx_output_buffer.sv
// rx_output_buffer: FIFO between the UART receiver and a valid/ready consumer.
//   OutBuf_CLK/OutBuf_RST          clock, active-low synchronous reset
//   OutBuf_Pdata_in/ParErr/StpErr  frame captured on OutBuf_DataValid_in
//   OutBuf_Ready_in                consumer accepts head frame
//   OutBuf_OvrClr_in               clears sticky overrun
//   OutBuf_*_out                   head frame, valid, occupancy, overrun
module rx_output_buffer
    import rx_output_buffer_pkg::*;
#(
    parameter int DataWIDTH  = DATA_WIDTH_DEF,
    parameter int DEPTH_LOG2 = DEPTH_LOG2_DEF
) (
    input  logic                    OutBuf_CLK,
    input  logic                    OutBuf_RST,
    input  logic [2**DataWIDTH-1:0] OutBuf_Pdata_in,
    input  logic                    OutBuf_DataValid_in,
    input  logic                    OutBuf_ParErr_in,
    input  logic                    OutBuf_StpErr_in,
    input  logic                    OutBuf_Ready_in,
    input  logic                    OutBuf_OvrClr_in,
    output logic [2**DataWIDTH-1:0] OutBuf_Pdata_out,
    output logic                    OutBuf_ParErr_out,
    output logic                    OutBuf_StpErr_out,
    output logic                    OutBuf_Valid_out,
    output logic [DEPTH_LOG2:0]     OutBuf_Count_out,
    output logic                    OutBuf_Overrun_out
);
    localparam int DW = 2**DataWIDTH;
    localparam int FW = frame_w(DataWIDTH);

    logic [DEPTH_LOG2:0] wr_ptr, rd_ptr;
    logic [FW-1:0]       head;
    logic                empty, full, push, pop, ovr_set;

    assign empty   = wr_ptr == rd_ptr;
    assign full    = (wr_ptr[DEPTH_LOG2] != rd_ptr[DEPTH_LOG2]) &&
                     (wr_ptr[DEPTH_LOG2-1:0] == rd_ptr[DEPTH_LOG2-1:0]);
    assign pop     = !empty && OutBuf_Ready_in;
    // A pop on the same edge frees the slot, so a full FIFO can still accept.
    assign push    = OutBuf_DataValid_in && (!full || pop);
    assign ovr_set = OutBuf_DataValid_in && full && !pop;

    rx_buf_mem #(.W(FW), .AW(DEPTH_LOG2)) u_mem (
        .clk  (OutBuf_CLK),
        .rst_n(OutBuf_RST),
        .we   (push),
        .wa   (wr_ptr[DEPTH_LOG2-1:0]),
        .wd   ({OutBuf_ParErr_in, OutBuf_StpErr_in, OutBuf_Pdata_in}),
        .ra   (rd_ptr[DEPTH_LOG2-1:0]),
        .rd   (head)
    );

    always_ff @(posedge OutBuf_CLK) begin
        if (!OutBuf_RST) begin
            wr_ptr             <= '0;
            rd_ptr             <= '0;
            OutBuf_Overrun_out <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + (DEPTH_LOG2+1)'(1);
            if (pop) rd_ptr <= rd_ptr + (DEPTH_LOG2+1)'(1);
            // Set takes priority over clear.
            OutBuf_Overrun_out <= ovr_set || (OutBuf_Overrun_out && !OutBuf_OvrClr_in);
        end
    end

    assign OutBuf_Pdata_out  = head[DW-1:0];
    assign OutBuf_StpErr_out = head[stp_err_bit(DataWIDTH)];
    assign OutBuf_ParErr_out = head[par_err_bit(DataWIDTH)];
    assign OutBuf_Valid_out  = !empty;
    assign OutBuf_Count_out  = wr_ptr - rd_ptr;
endmodule

// File: tb/tb_rx_output_buffer.sv
// tb_rx_output_buffer: directed scoreboard bench for rx_output_buffer.
module tb_rx_output_buffer;
    localparam int DW = 8;
    localparam int N  = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [DW-1:0] pdata_in = '0;
    logic          dv = 1'b0, par_in = 1'b0, stp_in = 1'b0, ready = 1'b0, clr = 1'b0;
    logic [DW-1:0] pdata_out;
    logic          par_out, stp_out, valid_out, ovr_out;
    logic [2:0]    count_out;

    int            checks = 0;
    int            errors = 0;
    logic [9:0]    sb [$];
    logic          ovr_m = 1'b0;

    always #5 clk = ~clk;

    rx_output_buffer #(.DataWIDTH(3), .DEPTH_LOG2(2)) dut (
        .OutBuf_CLK         (clk),
        .OutBuf_RST         (rst_n),
        .OutBuf_Pdata_in    (pdata_in),
        .OutBuf_DataValid_in(dv),
        .OutBuf_ParErr_in   (par_in),
        .OutBuf_StpErr_in   (stp_in),
        .OutBuf_Ready_in    (ready),
        .OutBuf_OvrClr_in   (clr),
        .OutBuf_Pdata_out   (pdata_out),
        .OutBuf_ParErr_out  (par_out),
        .OutBuf_StpErr_out  (stp_out),
        .OutBuf_Valid_out   (valid_out),
        .OutBuf_Count_out   (count_out),
        .OutBuf_Overrun_out (ovr_out)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_state(input string tag);
        chk({tag, " count"}, 32'(count_out), 32'(sb.size()));
        chk({tag, " valid"}, 32'(valid_out), 32'(sb.size() != 0));
        chk({tag, " overrun"}, 32'(ovr_out), 32'(ovr_m));
        if (sb.size() != 0)
            chk({tag, " head"}, 32'({par_out, stp_out, pdata_out}), 32'(sb[0]));
    endtask

    // Drive one cycle of stimulus, advance the model, then check outputs.
    task automatic step(input string tag, input logic d, input logic [7:0] data,
                        input logic p, input logic s, input logic r, input logic c);
        logic do_pop, do_push;
        dv = d; pdata_in = data; par_in = p; stp_in = s; ready = r; clr = c;
        do_pop  = (sb.size() != 0) && r;
        do_push = d && (sb.size() < N || do_pop);
        if (d && sb.size() == N && !do_pop) ovr_m = 1'b1;
        else if (c) ovr_m = 1'b0;
        @(posedge clk); #1;
        if (do_pop) void'(sb.pop_front());
        if (do_push) sb.push_back({p, s, data});
        dv = 0; ready = 0; clr = 0; par_in = 0; stp_in = 0;
        check_state(tag);
    endtask

    task automatic do_reset(input string tag);
        rst_n = 1'b0; dv = 1'b1; pdata_in = 8'hEE; ready = 1'b1; clr = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1; dv = 1'b0; ready = 1'b0;
        sb.delete();
        ovr_m = 1'b0;
        chk({tag, " data"}, 32'(pdata_out), 0);
        chk({tag, " par"}, 32'(par_out), 0);
        chk({tag, " stp"}, 32'(stp_out), 0);
        check_state(tag);
    endtask

    initial begin
        @(posedge clk); #1;
        do_reset("rst0");
        step("pre1", 1, 8'h5A, 1, 0, 0, 0);
        step("pre2", 1, 8'h6B, 0, 1, 0, 0);
        do_reset("rst_full");
        step("a5_push", 1, 8'hA5, 0, 0, 0, 0);
        chk("a5_data", 32'(pdata_out), 32'h A5);
        step("a5_pop", 0, 8'h00, 0, 0, 1, 0);
        step("fill11", 1, 8'h11, 0, 0, 0, 0);
        step("fill22", 1, 8'h22, 1, 0, 0, 0);
        step("fill33", 1, 8'h33, 0, 1, 0, 0);
        step("fill44", 1, 8'h44, 0, 0, 0, 0);
        chk("full_count", 32'(count_out), 4);
        step("drop55", 1, 8'h55, 0, 0, 0, 0);
        chk("drop55_ovr", 32'(ovr_out), 1);
        chk("drop55_head", 32'(pdata_out), 32'h11);
        step("clr_vs_set", 1, 8'h56, 0, 0, 0, 1);
        chk("set_wins", 32'(ovr_out), 1);
        step("clr_alone", 0, 8'h00, 0, 0, 0, 1);
        chk("cleared", 32'(ovr_out), 0);
        step("full_pp66", 1, 8'h66, 0, 0, 1, 0);
        chk("pp_count", 32'(count_out), 4);
        step("drain1", 0, 8'h00, 0, 0, 1, 0);
        step("drain2", 0, 8'h00, 0, 0, 1, 0);
        step("drain3", 0, 8'h00, 0, 0, 1, 0);
        chk("last66", 32'(pdata_out), 32'h66);
        step("drain4", 0, 8'h00, 0, 0, 1, 0);
        step("ready_empty", 0, 8'h00, 0, 0, 1, 0);
        for (int i = 0; i < 256; i++) begin
            step("stream", 1, 8'(i), i[0], i[1], 1, 0);
            chk("stream_count", 32'(count_out), 1);
        end
        step("stream_end", 0, 8'h00, 0, 0, 1, 0);
        step("mid1", 1, 8'h77, 0, 0, 0, 0);
        step("mid2", 1, 8'h78, 1, 1, 0, 0);
        do_reset("rst_mid");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
